// File: rtl/prbs_stream_arbiter.sv
// ---------------------------------------------------------------------------
// prbs_stream_arbiter
//
// Purpose
//   Shares one external PRBS generator (sync active-high rst, enable,
//   data_out) among NUM_REQ requesters. Requesters are granted round-robin.
//   The generator can optionally be reseeded before a burst. The burst
//   streams req_len words over a valid/ready output tagged with the
//   requester id.
//
// Ports
//   clk, rst_n   single clock; asynchronous active-low reset
//   req_valid    per-requester burst request, held until req_ack
//   req_reseed   per-requester "reseed generator first", sampled at grant
//   req_len      per-requester word count, slice i = [i*LEN_W +: LEN_W];
//                0 means 2^LEN_W words; sampled at grant
//   req_ack      one-hot, registered, single-cycle grant pulse
//   gen_rst      registered reset to the generator (high in SEED / reset)
//   gen_enable   generator advance strobe = out_valid & out_ready
//   gen_data     generator data_out
//   out_valid    registered output-word valid
//   out_ready    downstream accept
//   out_data     combinational pass-through of gen_data
//   out_last     high with the final word of the burst
//   out_id       registered index of the granted requester
//   busy         high whenever the FSM is not IDLE
//   state_dbg    current FSM state (0 IDLE, 1 SEED, 2 STREAM)
//
// Handshake: a word transfers on every cycle where out_valid and out_ready
// are both high. Once out_valid is raised it stays high, with out_data
// unchanged, until that transfer happens. out_data is taken straight from
// the generator, and the generator advances only on a transfer.
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module prbs_stream_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int LEN_W      = 8,
    parameter  int DATA_WIDTH = `WORD_SIZE,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_reseed,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     gen_rst,
    output logic                     gen_enable,
    input  logic [DATA_WIDTH-1:0]    gen_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic [ID_W-1:0]          out_id,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [LEN_W-1:0]  count;

    logic              any_req;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     cand_sum;
    logic [ID_W-1:0]   cand;
    logic              grant;
    logic              beat;
    logic [NUM_REQ-1:0] grant_onehot;

    // Per-requester word counts unpacked for indexed access by the winner.
    logic [LEN_W-1:0]  len_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
        assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
    end

    // -----------------------------------------------------------------------
    // Round-robin search: candidates rr_ptr+1, rr_ptr+2, ... wrapping at
    // NUM_REQ. The sum is one bit wider so the wrap also works when NUM_REQ
    // is not a power of two.
    // -----------------------------------------------------------------------
    always_comb begin
        any_req  = 1'b0;
        winner   = rr_ptr;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign grant        = (state == ST_IDLE) && any_req;
    assign beat         = out_valid && out_ready;
    assign grant_onehot = NUM_REQ'(1) << winner;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = req_reseed[winner] ? ST_SEED : ST_STREAM;
                end
            end
            ST_SEED: begin
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                // count holds "words remaining after this one".
                if (beat && (count == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: combinational outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy       = (state != ST_IDLE);
        gen_enable = beat;
        out_last   = out_valid && (count == '0);
        out_data   = gen_data;
        state_dbg  = state;
    end

    // -----------------------------------------------------------------------
    // Registered outputs and burst bookkeeping.
    // out_valid and gen_rst are decoded from the next state, so each one is
    // a flop that lines up exactly with STREAM / SEED.
    // gen_rst resets to 1, so the generator is reseeded on the first clock
    // edge after rst_n is released.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            out_id    <= '0;
            req_ack   <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            gen_rst   <= 1'b1;
        end else begin
            req_ack   <= '0;
            out_valid <= (state_next == ST_STREAM);
            gen_rst   <= (state_next == ST_SEED);
            if (grant) begin
                rr_ptr  <= winner;
                out_id  <= winner;
                req_ack <= grant_onehot;
                // A length of 0 wraps to all-ones, which gives 2^LEN_W beats.
                count   <= len_arr[winner] - LEN_W'(1);
            end else if (beat && (count != '0)) begin
                count <= count - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prbs_stream_arbiter
//
// Directed bench for prbs_stream_arbiter with a behavioural PRBS generator
// (16-bit LFSR, x^16+x^14+x^13+x^11+1, seed 0xACE1) acting as the shared
// generator. A cycle-level reference model predicts the grant, valid, last,
// id and data on every cycle. The directed sections also pin literal values.
// ---------------------------------------------------------------------------
module tb_prbs_stream_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LEN_W      = 8;
    localparam int DATA_WIDTH = 16;
    localparam int ID_W       = 2;
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    localparam int P_IDLE   = 0;
    localparam int P_SEED   = 1;
    localparam int P_STREAM = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_reseed;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ack;
    logic                     gen_rst;
    logic                     gen_enable;
    logic [DATA_WIDTH-1:0]    gen_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_last;
    logic [ID_W-1:0]          out_id;
    logic                     busy;
    logic [1:0]               state_dbg;

    prbs_stream_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LEN_W      (LEN_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_reseed (req_reseed),
        .req_len    (req_len),
        .req_ack    (req_ack),
        .gen_rst    (gen_rst),
        .gen_enable (gen_enable),
        .gen_data   (gen_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_id     (out_id),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] beat_data[$];
    logic        beat_last[$];
    logic [ID_W-1:0] beat_id[$];
    int          ack_q[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- generator shared by the requesters ----------------
    logic [15:0] gen_state;
    always @(posedge clk) begin
        if (gen_rst) gen_state <= LFSR_INIT;
        else if (gen_enable) gen_state <= lfsr_next(gen_state);
    end
    assign gen_data = gen_state;

    // ---------------- reference model ----------------
    int          m_phase;
    int          m_left;
    int          m_ptr;
    int          m_id;
    logic [3:0]  m_ack;
    logic        m_gen_rst;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= P_IDLE;
            m_left    <= 0;
            m_ptr     <= NUM_REQ - 1;
            m_id      <= 0;
            m_ack     <= '0;
            m_gen_rst <= 1'b1;
            m_lfsr    <= LFSR_INIT;
        end else begin : step
            int ph, left, ptr, id, c, l;
            bit found;
            logic [3:0]  ack;
            logic [15:0] lf;
            ph = m_phase; left = m_left; ptr = m_ptr; id = m_id; lf = m_lfsr;
            ack = '0; found = 1'b0;
            if (ph == P_IDLE) begin
                for (int off = 1; off <= NUM_REQ; off++) begin
                    c = (m_ptr + off) % NUM_REQ;
                    if (!found && req_valid[c]) begin
                        found  = 1'b1;
                        ptr    = c;
                        id     = c;
                        ack[c] = 1'b1;
                        l      = int'(req_len[c*LEN_W +: LEN_W]);
                        left   = (l == 0) ? (1 << LEN_W) : l;
                        ph     = req_reseed[c] ? P_SEED : P_STREAM;
                    end
                end
            end else if (ph == P_SEED) begin
                lf = LFSR_INIT;
                ph = P_STREAM;
            end else begin
                if (out_ready) begin
                    lf   = lfsr_next(lf);
                    left = left - 1;
                    if (left == 0) ph = P_IDLE;
                end
            end
            m_phase   <= ph;
            m_left    <= left;
            m_ptr     <= ptr;
            m_id      <= id;
            m_ack     <= ack;
            m_gen_rst <= (ph == P_SEED);
            m_lfsr    <= lf;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        prev_stall;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ack", req_ack, m_ack);
            check("out_valid", out_valid, m_phase == P_STREAM);
            check("busy", busy, m_phase != P_IDLE);
            check("gen_rst", gen_rst, m_gen_rst);
            check("gen_enable", gen_enable, (m_phase == P_STREAM) && out_ready);
            check("out_last", out_last, (m_phase == P_STREAM) && (m_left == 1));
            if (m_phase == P_STREAM) begin
                check("out_id", out_id, m_id);
                check("out_data", out_data, m_lfsr);
            end
            if (prev_stall && out_valid) check("stall_hold", out_data, prev_data);
        end
        prev_stall <= out_valid && !out_ready;
        prev_data  <= out_data;
    end

    // ---------------- beat / grant monitor ----------------
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_data.push_back(out_data);
            beat_last.push_back(out_last);
            beat_id.push_back(out_id);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i] === 1'b1) ack_q.push_back(i);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit rs, input int len);
        req_valid[i]  = v;
        req_reseed[i] = rs;
        req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic clear_logs();
        beat_data.delete();
        beat_last.delete();
        beat_id.delete();
        ack_q.delete();
    endtask

    task automatic wait_ack(input int i, input string name);
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (req_ack[i] === 1'b1) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) break;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic check_stream(input string name, input int n_exp, input int id_exp);
        check({name, "_beats"}, beat_data.size(), n_exp);
        for (int i = 0; i < beat_data.size() && i < n_exp; i++) begin
            if (i < exp_q.size()) check({name, "_data"}, beat_data[i], exp_q[i]);
            check({name, "_last"}, beat_last[i], i == n_exp - 1);
            check({name, "_id"}, beat_id[i], id_exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200us;
        failures++;
        $display("FAIL watchdog simulation did not complete actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int stalls;
        int lasts;
        int nb;
        int na;
        logic [3:0] pat;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_reseed = '0;
        req_len    = '0;
        out_ready  = 1'b0;

        // 1: reset values, gen_rst held through the first edge after release
        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("t1_rst_gen_rst", gen_rst, 1'b1);
        check("t1_rst_busy", busy, 1'b0);
        check("t1_rst_valid", out_valid, 1'b0);
        check("t1_rst_ack", req_ack, 4'b0000);
        check("t1_rst_id", out_id, 2'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t1_gen_rst_before_edge", gen_rst, 1'b1);
        @(negedge clk);
        check("t1_gen_rst_cleared", gen_rst, 1'b0);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_ack", req_ack, 4'b0000);
        repeat (2) tick();

        // 2: req0, len 3, reseed -> SEED cycle then ACE1, 59C3, B387
        clear_logs();
        set_req(0, 1'b1, 1'b1, 3);
        out_ready = 1'b1;
        wait_ack(0, "t2_ack");
        check("t2_seed_gen_rst", gen_rst, 1'b1);
        check("t2_seed_no_valid", out_valid, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t2_first_valid", out_valid, 1'b1);
        wait_done("t2_done", 20);
        exp_q = {16'hACE1, 16'h59C3, 16'hB387};
        check_stream("t2", 3, 0);
        check("t2_single_ack", ack_q.size(), 1);

        // 3: all requesters held, len 1 -> grants 0,1,2,3,0 (pointer reset first)
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 1);
        na = 0;
        for (int n = 0; n < 60 && na < 5; n++) begin
            @(negedge clk);
            if (req_ack !== 4'b0000) na++;
        end
        check("t3_five_acks_seen", na, 5);
        tick();
        req_valid = '0;
        wait_done("t3_done", 20);
        check("t3_ack_count", ack_q.size(), 5);
        check("t3_beat_count", beat_data.size(), 5);
        exp_q = {16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        for (int i = 0; i < ack_q.size() && i < 5; i++) check("t3_grant_order", ack_q[i], exp_q[i]);
        for (int i = 0; i < beat_id.size() && i < 5; i++) begin
            check("t3_beat_id", beat_id[i], exp_q[i]);
            check("t3_beat_last", beat_last[i], 1'b1);
        end

        // 4: req2, len 0 -> 256 beats, last only on the final one
        tick();
        clear_logs();
        exp_q.delete();
        set_req(2, 1'b1, 1'b0, 0);
        wait_ack(2, "t4_ack");
        tick();
        req_valid[2] = 1'b0;
        wait_done("t4_done", 400);
        check_stream("t4", 256, 2);
        lasts = 0;
        foreach (beat_last[i]) if (beat_last[i]) lasts++;
        check("t4_last_count", lasts, 1);

        // 5: out_ready pattern 1,0,0,1 during a reseeded burst of 4
        tick();
        clear_logs();
        pat = 4'b1001;
        set_req(1, 1'b1, 1'b1, 4);
        out_ready = 1'b1;
        wait_ack(1, "t5_ack");
        tick();
        req_valid[1] = 1'b0;
        out_ready = pat[3];
        stalls = 0;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
            if (out_valid && !out_ready) begin
                stalls++;
                check("t5_stall_no_enable", gen_enable, 1'b0);
            end
            tick();
            out_ready = pat[3 - (k % 4)];
        end
        check("t5_done", busy, 1'b0);
        out_ready = 1'b1;
        check("t5_stalled_some", stalls > 0, 1'b1);
        exp_q = {16'hACE1, 16'h59C3, 16'hB387, 16'h670F};
        check_stream("t5", 4, 1);

        // 6: reset mid-burst after beat 2 of 5, then req0 streams from seed
        tick();
        clear_logs();
        set_req(1, 1'b1, 1'b1, 5);
        wait_ack(1, "t6_ack");
        tick();
        req_valid[1] = 1'b0;
        nb = 0;
        for (int n = 0; n < 20 && nb < 2; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) nb++;
        end
        check("t6_two_beats", nb, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 1'b0);
        check("t6_async_busy", busy, 1'b0);
        check("t6_async_ack", req_ack, 4'b0000);
        check("t6_async_id", out_id, 2'd0);
        check("t6_async_gen_rst", gen_rst, 1'b1);
        check("t6_async_last", out_last, 1'b0);
        check("t6_async_enable", gen_enable, 1'b0);
        check("t6_beats_before_rst", beat_data.size(), 2);
        lasts = 0;
        foreach (beat_last[i]) if (beat_last[i]) lasts++;
        check("t6_no_last", lasts, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        clear_logs();
        set_req(0, 1'b1, 1'b0, 3);
        wait_ack(0, "t6_req0_ack");
        tick();
        req_valid[0] = 1'b0;
        wait_done("t6_req0_done", 20);
        exp_q = {16'hACE1, 16'h59C3, 16'hB387};
        check_stream("t6_req0", 3, 0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
